// File: rtl/mem_copy_master_pkg.sv
// Shared types and constants for the memory-copy bus master.
package mem_copy_master_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = 4;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [STRB_W-1:0] WSTRB_WORD = 4'hF;
    localparam logic [STRB_W-1:0] WSTRB_NONE = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_RD_GAP = 3'd2,
        ST_WR_REQ = 3'd3,
        ST_WR_GAP = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // Clear the byte-offset bits so every bus address is word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/mem_req_watchdog.sv
// Counts cycles a bus request waits for mem_ready; flags expiry on the last allowed cycle.
module mem_req_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    // Expiry is seen during the TIMEOUT_CYCLES-th waiting cycle so the FSM can drop valid right after it.
    assign o_expired_c = i_enable && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter: held at zero outside requests, saturates at expiry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired_c) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_copy_master.sv
// Simple DMA engine on the native mem_valid/mem_ready bus: read one word, write it, repeat.
module mem_copy_master
    import mem_copy_master_pkg::*;
#(
    parameter int unsigned COUNT_W        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [ADDR_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0]  dst_addr,
    input  logic [COUNT_W-1:0] word_count,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               mem_valid,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [STRB_W-1:0]  mem_wstrb,
    input  logic               mem_ready,
    input  logic [DATA_W-1:0]  mem_rdata
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [COUNT_W-1:0]  r_count;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic                r_mem_valid;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [STRB_W-1:0]   r_mem_wstrb;

    state_t              w_next_state;
    logic [ADDR_W-1:0]   w_src;
    logic [ADDR_W-1:0]   w_dst;
    logic [COUNT_W-1:0]  w_count;
    logic                w_busy;
    logic                w_done;
    logic                w_error;
    logic                w_mem_valid;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [STRB_W-1:0]   w_mem_wstrb;
    logic                w_in_req;
    logic                w_expired;

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

    assign w_in_req = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);

    mem_req_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .resetn      (resetn),
        .i_clear     (!w_in_req),
        .i_enable    (w_in_req && !mem_ready),
        .o_expired_c (w_expired)
    );

    // Next-state and next-output logic; a handshake takes priority over a same-cycle timeout.
    always_comb begin
        w_next_state = r_state;
        w_src        = r_src;
        w_dst        = r_dst;
        w_count      = r_count;
        w_done       = 1'b0;
        w_error      = 1'b0;
        w_mem_valid  = r_mem_valid;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_mem_wstrb  = r_mem_wstrb;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_src   = word_align(src_addr);
                    w_dst   = word_align(dst_addr);
                    w_count = word_count;
                    if (word_count == '0) begin
                        w_next_state = ST_FINISH;
                    end else begin
                        w_next_state = ST_RD_REQ;
                        w_mem_valid  = 1'b1;
                        w_mem_addr   = word_align(src_addr);
                        w_mem_wstrb  = WSTRB_NONE;
                    end
                end
            end
            ST_RD_REQ: begin
                if (mem_ready) begin
                    w_mem_wdata  = mem_rdata;
                    w_mem_valid  = 1'b0;
                    w_next_state = ST_RD_GAP;
                end else if (w_expired) begin
                    w_mem_valid  = 1'b0;
                    w_error      = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD_GAP: begin
                w_next_state = ST_WR_REQ;
                w_mem_valid  = 1'b1;
                w_mem_addr   = r_dst;
                w_mem_wstrb  = WSTRB_WORD;
            end
            ST_WR_REQ: begin
                if (mem_ready) begin
                    w_src        = r_src + ADDR_W'(WORD_BYTES);
                    w_dst        = r_dst + ADDR_W'(WORD_BYTES);
                    w_count      = r_count - COUNT_W'(1);
                    w_mem_valid  = 1'b0;
                    w_next_state = ST_WR_GAP;
                end else if (w_expired) begin
                    w_mem_valid  = 1'b0;
                    w_error      = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_WR_GAP: begin
                if (r_count == '0) begin
                    w_next_state = ST_FINISH;
                end else begin
                    w_next_state = ST_RD_REQ;
                    w_mem_valid  = 1'b1;
                    w_mem_addr   = r_src;
                    w_mem_wstrb  = WSTRB_NONE;
                end
            end
            ST_FINISH: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_mem_valid  = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase

        w_busy = (w_next_state != ST_IDLE);
    end

    // State, datapath and registered bus outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= WSTRB_NONE;
        end else begin
            r_state     <= w_next_state;
            r_src       <= w_src;
            r_dst       <= w_dst;
            r_count     <= w_count;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_error     <= w_error;
            r_mem_valid <= w_mem_valid;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_wstrb <= w_mem_wstrb;
        end
    end

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: memory responder with programmable delays, protocol monitor, copy model.
module tb_mem_copy_master;

    localparam int unsigned COUNT_W        = 16;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic               clk = 1'b0;
    logic               resetn;
    logic               start;
    logic [31:0]        src_addr;
    logic [31:0]        dst_addr;
    logic [COUNT_W-1:0] word_count;
    logic               busy;
    logic               done;
    logic               error;
    logic               mem_valid;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_wstrb;
    logic               mem_ready = 1'b0;
    logic [31:0]        mem_rdata = 32'h0;

    int checks   = 0;
    int failures = 0;

    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    int          resp_rd_delay = 1;
    int          resp_wr_delay = 1;
    bit          resp_stub     = 1'b0;
    int          wcnt          = 0;

    logic        prev_resetn = 1'b0;
    logic        prev_valid  = 1'b0;
    logic        prev_ready  = 1'b0;
    logic [31:0] prev_addr   = 32'h0;
    logic [31:0] prev_wdata  = 32'h0;
    logic [3:0]  prev_wstrb  = 4'h0;

    always #5 clk = ~clk;

    mem_copy_master #(
        .COUNT_W        (COUNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Protocol monitor followed by the responder, both on the falling edge.
    always @(negedge clk) begin : responder
        if (resetn && prev_resetn) begin
            if (prev_valid && !prev_ready && mem_valid) begin
                check("hold_addr",  64'(mem_addr),  64'(prev_addr));
                check("hold_wdata", 64'(mem_wdata), 64'(prev_wdata));
                check("hold_wstrb", 64'(mem_wstrb), 64'(prev_wstrb));
            end
            if (prev_valid && prev_ready)
                check("gap_after_ready", 64'(mem_valid), 64'(0));
            if (mem_valid)
                check("addr_aligned", 64'(mem_addr[1:0]), 64'(0));
        end

        if (!resetn) begin
            mem_ready = 1'b0;
            wcnt      = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            wcnt      = 0;
            mem_rdata = $urandom;
        end else if (mem_valid && !resp_stub) begin
            wcnt++;
            mem_rdata = $urandom;
            if (wcnt >= ((mem_wstrb == 4'hF) ? resp_wr_delay : resp_rd_delay)) begin
                mem_ready = 1'b1;
                wcnt      = 0;
                if (mem_wstrb == 4'hF) begin
                    mem[mem_addr] = mem_wdata;
                    log_q.push_back({1'b1, mem_addr, mem_wdata});
                end else begin
                    mem_rdata = mem_rd(mem_addr);
                    log_q.push_back({1'b0, mem_addr, mem_rdata});
                end
            end
        end else begin
            mem_rdata = $urandom;
        end

        prev_resetn = resetn;
        prev_valid  = mem_valid;
        prev_ready  = mem_ready;
        prev_addr   = mem_addr;
        prev_wdata  = mem_wdata;
        prev_wstrb  = mem_wstrb;
    end

    // Reference: word-by-word copy, each word a read of src then a write to dst.
    task automatic build_expected(input logic [31:0] src, input logic [31:0] dst, input int n);
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] data;
        exp_q.delete();
        ref_mem = mem;
        s = src & ~32'h3;
        d = dst & ~32'h3;
        for (int i = 0; i < n; i++) begin
            data = ref_mem.exists(s) ? ref_mem[s] : 32'h0;
            exp_q.push_back({1'b0, s, data});
            ref_mem[d] = data;
            exp_q.push_back({1'b1, d, data});
            s = s + 32'd4;
            d = d + 32'd4;
        end
    endtask

    task automatic compare_log(input bool_prefix_only);
        int n;
        if (!bool_prefix_only)
            check("log_len", 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("txn_wr",   64'(log_q[i].wr),   64'(exp_q[i].wr));
            check("txn_addr", 64'(log_q[i].addr), 64'(exp_q[i].addr));
            check("txn_data", 64'(log_q[i].data), 64'(exp_q[i].data));
        end
    endtask

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                            input int rd, input int wr);
        int cyc;
        int vcyc;
        int budget;
        build_expected(src, dst, n);
        resp_rd_delay = rd;
        resp_wr_delay = wr;
        log_q.delete();
        @(negedge clk);
        start      = 1'b1;
        src_addr   = src;
        dst_addr   = dst;
        word_count = COUNT_W'(n);
        @(negedge clk);
        start      = 1'b0;
        src_addr   = $urandom;
        dst_addr   = $urandom;
        word_count = COUNT_W'($urandom);
        cyc    = 1;
        vcyc   = 0;
        budget = n * (rd + wr + 2) + 20;
        check("busy_after_start", 64'(busy), 64'(1));
        while (!done && !error && cyc < budget) begin
            if (mem_valid) vcyc++;
            @(negedge clk);
            cyc++;
        end
        check("done_seen",    64'(done),  64'(1));
        check("no_error",     64'(error), 64'(0));
        check("busy_at_done", 64'(busy),  64'(0));
        check("latency",      64'(cyc),   64'(n * (rd + wr + 2) + 2));
        check("valid_cycles", 64'(vcyc),  64'(n * (rd + wr)));
        compare_log(1'b0);
        foreach (exp_q[i]) begin
            if (exp_q[i].wr)
                check("mem_final", 64'(mem_rd(exp_q[i].addr)), 64'(ref_mem[exp_q[i].addr]));
        end
        @(negedge clk);
        check("done_single", 64'(done), 64'(0));
        check("busy_idle",   64'(busy), 64'(0));
    endtask

    initial begin : global_guard
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        int          cyc;
        int          vcyc;
        bit          seen_done;
        bit          seen_err;
        logic [31:0] s;
        logic [31:0] d;
        int          n;

        start      = 1'b0;
        src_addr   = 32'h0;
        dst_addr   = 32'h0;
        word_count = '0;
        resetn     = 1'b1;
        #1 resetn  = 1'b0;
        #1;
        check("rst_busy",  64'(busy),      64'(0));
        check("rst_done",  64'(done),      64'(0));
        check("rst_error", 64'(error),     64'(0));
        check("rst_valid", 64'(mem_valid), 64'(0));
        check("rst_addr",  64'(mem_addr),  64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        check("rst_wstrb", 64'(mem_wstrb), 64'(0));
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed copy of four preloaded words.
        for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        run_copy(32'h100, 32'h200, 4, 2, 1);
        for (int i = 0; i < 4; i++)
            check("copy4_dst", 64'(mem_rd(32'h200 + 32'(4 * i))), 64'(32'hA0 + 32'(i)));

        // Zero-length transfer.
        run_copy(32'h300, 32'h340, 0, 1, 1);

        // Unaligned source and wrapping destination.
        mem[32'h100] = 32'h1111_2222;
        mem[32'h104] = 32'h3333_4444;
        run_copy(32'h103, 32'hFFFF_FFFC, 2, 1, 2);
        if (log_q.size() == 4) begin
            check("wrap_rd0", 64'(log_q[0].addr), 64'(32'h100));
            check("wrap_wr0", 64'(log_q[1].addr), 64'(32'hFFFF_FFFC));
            check("wrap_rd1", 64'(log_q[2].addr), 64'(32'h104));
            check("wrap_wr1", 64'(log_q[3].addr), 64'(32'h0));
        end

        // Randomized copies.
        for (int t = 0; t < 5; t++) begin
            s = 32'h1000_0000 | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) mem[(s & ~32'h3) + 32'(4 * i)] = $urandom;
            run_copy(s, d, n, $urandom_range(1, 4), $urandom_range(1, 4));
        end

        // Silent responder: watchdog must abandon the transfer.
        resp_stub = 1'b1;
        log_q.delete();
        @(negedge clk);
        start      = 1'b1;
        src_addr   = 32'h300;
        dst_addr   = 32'h400;
        word_count = COUNT_W'(3);
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        vcyc      = 0;
        seen_done = 1'b0;
        while (!error && cyc < 200) begin
            if (mem_valid) vcyc++;
            if (done) seen_done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("wd_error",     64'(error),      64'(1));
        check("wd_cycle",     64'(cyc),        64'(TIMEOUT_CYCLES + 1));
        check("wd_valid_cyc", 64'(vcyc),       64'(TIMEOUT_CYCLES));
        check("wd_valid_low", 64'(mem_valid),  64'(0));
        check("wd_busy_low",  64'(busy),       64'(0));
        check("wd_no_done",   64'(seen_done),  64'(0));
        check("wd_no_txn",    64'(log_q.size()), 64'(0));
        @(negedge clk);
        check("wd_err_single", 64'(error),     64'(0));
        check("wd_idle_valid", 64'(mem_valid), 64'(0));
        resp_stub = 1'b0;

        // Second start while busy, then reset during a write.
        for (int i = 0; i < 4; i++) mem[32'h500 + 32'(4 * i)] = $urandom;
        build_expected(32'h500, 32'h600, 4);
        resp_rd_delay = 2;
        resp_wr_delay = 3;
        log_q.delete();
        @(negedge clk);
        start      = 1'b1;
        src_addr   = 32'h500;
        dst_addr   = 32'h600;
        word_count = COUNT_W'(4);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start      = 1'b1;
        src_addr   = 32'h900;
        dst_addr   = 32'hA00;
        word_count = '0;
        @(negedge clk);
        start     = 1'b0;
        cyc       = 0;
        seen_done = 1'b0;
        seen_err  = 1'b0;
        while (!(mem_valid && mem_wstrb == 4'hF && log_q.size() >= 3) && cyc < 100) begin
            if (done)  seen_done = 1'b1;
            if (error) seen_err  = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("rs_reached_write", 64'(mem_valid && mem_wstrb == 4'hF), 64'(1));
        check("rs_still_busy",    64'(busy),      64'(1));
        check("rs_no_done_pre",   64'(seen_done), 64'(0));
        check("rs_no_err_pre",    64'(seen_err),  64'(0));
        resetn = 1'b0;
        #1;
        check("rs_busy",  64'(busy),      64'(0));
        check("rs_done",  64'(done),      64'(0));
        check("rs_error", 64'(error),     64'(0));
        check("rs_valid", 64'(mem_valid), 64'(0));
        check("rs_addr",  64'(mem_addr),  64'(0));
        check("rs_wdata", 64'(mem_wdata), 64'(0));
        check("rs_wstrb", 64'(mem_wstrb), 64'(0));
        compare_log(1'b1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_busy",  64'(busy),      64'(0));
            check("post_rst_done",  64'(done),      64'(0));
            check("post_rst_error", 64'(error),     64'(0));
            check("post_rst_valid", 64'(mem_valid), 64'(0));
        end

        // Engine must come back usable from IDLE.
        mem[32'h700] = 32'hDEAD_BEEF;
        run_copy(32'h700, 32'h800, 1, 1, 1);
        check("post_rst_copy", 64'(mem_rd(32'h800)), 64'(32'hDEAD_BEEF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
